data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Memory-side end of the core's data-memory handshake. It consumes mem_in_s
//  plus the byte address, and returns mem_out_s. It owns a word-organised
//  synchronous RAM and accepts one LW/LBU/SW/SB request at a time. After a
//  fixed latency it returns a response and holds it until the core yumi's it.
//  Sits between core.to_mem_o/data_mem_addr and core.from_mem_i.
// PARAMETERS
//  addr_width_p  10  word-address bits; RAM depth = 2**addr_width_p 32-bit words
//  latency_p     2   cycles from accept to response valid; legal range 1..15
// PORTS
//  clk          in   1          clock
//  reset        in   1          asynchronous, active-low reset
//  to_mem_i     in   mem_in_s   write_data, valid, wen, byte_not_word, yumi from core
//  addr_i       in   32         byte address of the request (core data_mem_addr)
//  from_mem_o   out  mem_out_s  read_data[31:0], valid (response), yumi (request accepted)
//  busy_o       out  1          request outstanding (state != IDLE)
// BEHAVIOUR
//  - Clock and reset
//    - One clock domain. Reset is asynchronous, active-low.
//    - Reset values: from_mem_o.valid=0, from_mem_o.yumi=0, read_data=0,
//      busy_o=0, state=IDLE, counter=0.
//    - RAM contents are not reset.
//  - FSM states: IDLE, WAIT, RESP.
//  - IDLE
//    - from_mem_o.yumi = to_mem_i.valid. This is combinational, same cycle T.
//    - On accept, latch: word index addr_i[2+:addr_width_p], lane addr_i[1:0],
//      wen, byte_not_word, write_data. Load counter with latency_p-1.
//    - If latency_p==1 go to RESP, otherwise go to WAIT.
//  - WAIT
//    - Decrement the counter each cycle. Go to RESP when the counter reaches 0.
//    - from_mem_o.yumi=0. New requests are ignored, not queued.
//  - Entry into RESP (one-shot)
//    - This happens exactly once per request, on the edge that enters RESP
//      (edge ending cycle T+latency_p-1).
//    - Store word (wen & ~byte): write all 32 bits.
//    - Store byte (wen & byte): write only bits [8*lane+:8]; other bytes unchanged.
//    - Load word: read_data = mem[idx].
//    - Load byte (LBU): read_data = {24'b0, mem[idx][8*lane+:8]}.
//    - Store: read_data = 0.
//  - RESP
//    - from_mem_o.valid=1 from cycle T+latency_p onward.
//    - read_data is held stable until consumed.
//    - to_mem_i.yumi=1 consumes the response: go to IDLE next cycle, valid drops.
//  - Timing: minimum request-to-request spacing is latency_p+1 cycles. A request
//    present in the same cycle as the consuming yumi is not accepted then; it is
//    accepted earliest the following cycle (in IDLE).
//  - Width rules
//    - addr_i bits above 2+addr_width_p are ignored, so addresses wrap modulo RAM size.
//    - Word accesses ignore addr_i[1:0]; there is no misalignment fault.
//  - to_mem_i.yumi outside RESP has no effect.
//  - Request fields are sampled only at accept; later changes are ignored.
//  - Reset during WAIT/RESP: return to IDLE, drop the pending response.
//    A pending store that has not yet reached RESP entry is not written.
// TESTING
//  - Word round trip: SW 0xDEADBEEF @0x10, then LW @0x10 -> yumi@T, valid@T+2,
//    read_data=0xDEADBEEF.
//  - Byte lanes: SW 0x11223344 @0x20, SB 0xAA @0x22, then LBU @0x22 -> 0x000000AA;
//    LW @0x20 -> 0x11AA3344.
//  - Backpressure: hold to_mem_i.yumi=0 for 5 cycles in RESP -> valid and read_data
//    stay stable; consuming yumi -> IDLE next cycle.
//  - Busy rejection: assert valid continuously -> exactly one yumi per
//    latency_p+1 cycles. No request is duplicated or lost, and the final RAM
//    matches the golden model.
//  - Wrap: addr_width_p=10, SW 0x5 @0x1004 then LW @0x0004 -> 0x5.
//  - Async reset mid-op: assert reset in WAIT after SW 0x7 @0x30 -> all outputs 0
//    immediately. A subsequent LW @0x30 does not return 0x7.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time from the core and
// answers it from a word-organised synchronous RAM after a fixed latency. The
// response is held until the core acknowledges it with yumi.

package data_mem_responder_pkg;

    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;

endpackage

module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned addr_width_p = 10,
    parameter int unsigned latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     to_mem_i,
    input  logic [31:0] addr_i,
    output mem_out_s    from_mem_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam int unsigned Depth   = 2 ** addr_width_p;
    localparam logic [3:0]  CntLoad = 4'(latency_p - 1);

    state_e                  r_state;
    state_e                  w_state_next;
    logic [3:0]              r_cnt;
    logic [addr_width_p-1:0] r_idx;
    logic [1:0]              r_lane;
    logic                    r_wen;
    logic                    r_byte;
    logic [31:0]             r_wdata;
    logic [31:0]             r_read_data;
    logic [31:0]             r_mem [Depth];

    logic                    w_accept;
    logic                    w_enter_resp;
    logic [addr_width_p-1:0] w_cur_idx;
    logic [1:0]              w_cur_lane;
    logic                    w_cur_wen;
    logic                    w_cur_byte;
    logic [31:0]             w_cur_wdata;
    logic [31:0]             w_rd_word;
    logic [31:0]             w_rd_shift;
    logic [3:0]              w_be;
    logic [31:0]             w_wr_word;
    logic                    w_unused;

    // Address bits above the RAM index only make addresses wrap.
    assign w_unused = ^addr_i[31:2+addr_width_p];

    // Gated by reset so yumi reads 0 while reset is held.
    assign w_accept = (r_state == StIdle) & to_mem_i.valid & reset;

    // With latency 1 the RESP-entry edge is the accept edge itself, so the
    // live request fields must be used instead of the not-yet-latched copies.
    assign w_cur_idx   = (r_state == StIdle) ? addr_i[2+:addr_width_p] : r_idx;
    assign w_cur_lane  = (r_state == StIdle) ? addr_i[1:0]             : r_lane;
    assign w_cur_wen   = (r_state == StIdle) ? to_mem_i.wen            : r_wen;
    assign w_cur_byte  = (r_state == StIdle) ? to_mem_i.byte_not_word  : r_byte;
    assign w_cur_wdata = (r_state == StIdle) ? to_mem_i.write_data     : r_wdata;

    assign w_rd_word  = r_mem[w_cur_idx];
    assign w_rd_shift = w_rd_word >> {w_cur_lane, 3'b000};
    assign w_be       = w_cur_byte ? (4'b0001 << w_cur_lane) : 4'b1111;
    assign w_wr_word  = w_cur_byte ? {4{w_cur_wdata[7:0]}} : w_cur_wdata;

    // One-shot: true only on the edge that moves the FSM into RESP.
    assign w_enter_resp = (r_state != StResp) & (w_state_next == StResp);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = (latency_p == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                if (r_cnt <= 4'd1) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                if (to_mem_i.yumi) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Output decode.
    always_comb begin
        from_mem_o           = '0;
        from_mem_o.read_data = r_read_data;
        from_mem_o.valid     = (r_state == StResp);
        from_mem_o.yumi      = w_accept;
        busy_o               = (r_state != StIdle);
    end

    // Request latch and latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_lane  <= '0;
            r_wen   <= 1'b0;
            r_byte  <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= CntLoad;
            r_idx   <= addr_i[2+:addr_width_p];
            r_lane  <= addr_i[1:0];
            r_wen   <= to_mem_i.wen;
            r_byte  <= to_mem_i.byte_not_word;
            r_wdata <= to_mem_i.write_data;
        end else if (r_state == StWait && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Response data captured once on RESP entry and held until consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_read_data <= '0;
        end else if (w_enter_resp) begin
            if (w_cur_wen) begin
                r_read_data <= '0;
            end else if (w_cur_byte) begin
                r_read_data <= {24'b0, w_rd_shift[7:0]};
            end else begin
                r_read_data <= w_rd_word;
            end
        end
    end

    // RAM write with per-byte enables; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_cur_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_cur_idx][8*b+:8] <= w_wr_word[8*b+:8];
                end
            end
        end
    end

endmodule
